// File: rtl/mips_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// Pure declarations: no logic, no latency.
// Backpressure not applicable.
package mips_fetch_pkg;

  // Default fetch PC after reset (byte address).
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Value presented on the decode data bus when nothing is queued.
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  // One queued fetch: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;

  // Word index of a byte address; callers keep only the low ROM-address bits.
  function automatic logic [29:0] word_index(input logic [31:0] pc);
    return 30'(pc >> 2);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue holding {data, pc} entries between ROM and decode.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle; flush wins over push/pop.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [31:0]                  push_data,
  input  logic [31:0]                  push_pc,
  input  logic                         pop,
  input  logic                         flush,
  output logic                         head_valid,
  output logic [31:0]                  head_data,
  output logic [31:0]                  head_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  fetch_entry_t   head_entry;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic           not_full;
  logic           do_push;
  logic           do_pop;

  assign head_valid = (count != '0);
  assign not_full   = (count != CW'(DEPTH));
  assign do_pop     = pop & head_valid & ~flush;
  assign do_push    = push & (not_full | do_pop) & ~flush;

  assign head_entry = mem[head];
  assign head_data  = head_valid ? head_entry.data : INST_NOP;
  assign head_pc    = head_valid ? head_entry.pc   : 32'h0;

  // Entry storage: written at the tail on an accepted push; contents beyond count are don't-care.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= '{data: push_data, pc: push_pc};
    end
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the fetch PC, drives the ROM port, queues words and hands {inst, pc} to decode.
// Latency: ROM word appears at inst_* the cycle after it is fetched; redirect target two cycles after redirect.
// Backpressure: fetch (rom_sel) stalls while the queue is full and decode is not popping; PC holds.
// Optional fault checking enabled by defining INST_FETCH_FAULT_EN.
module inst_fetch
  import mips_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_sel,
  input  logic [31:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [31:0]       inst_pc,
  output logic              fetch_fault
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   redirect_target;
  logic [CW-1:0] count;
  logic          pop;
  logic          room;
  logic          fetch_try;
  logic          pc_bad;
  logic          fetch;
  logic          fault;

  assign pop  = inst_valid & inst_ready;
  assign room = (count < CW'(DEPTH)) | pop;

  // rst_n gates the select so the ROM is never addressed while reset is held.
  assign fetch_try = room & ~redirect_valid & ~fault & rst_n;
  assign fetch     = fetch_try & ~pc_bad;

  assign rom_sel     = fetch;
  assign rom_addr    = ADDR_W'(word_index(fetch_pc));
  assign fetch_fault = fault;

`ifdef INST_FETCH_FAULT_EN
  // Any PC bit above the ROM window makes the fetch illegal.
  assign pc_bad          = |fetch_pc[31:ADDR_W+2];
  assign redirect_target = redirect_pc;

  // Sticky fault: set by a misaligned redirect or an out-of-range fetch; a clean redirect clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (redirect_valid) begin
      fault <= |redirect_pc[1:0];
    end else if (fetch_try && pc_bad) begin
      fault <= 1'b1;
    end
  end
`else
  // Without checking, misaligned targets are word-aligned and the ROM index simply wraps.
  assign pc_bad          = 1'b0;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign fault           = 1'b0;
`endif

  // Fetch PC: redirect loads the target, otherwise advance one word per accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (fetch) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fetch),
    .push_data  (rom_data),
    .push_pc    (fetch_pc),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_valid (inst_valid),
    .head_data  (inst_data),
    .head_pc    (inst_pc),
    .count      (count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational 1024-word ROM model.
// Each cycle: inputs change 1ns after the rising edge, outputs sampled 1ns later.
// ROM word i holds 32'hC0DE_0000 + i.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rom_addr;
  logic        rom_sel;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  logic [31:0] rom [1024];

  int checks = 0;
  int passed = 0;

  inst_fetch #(
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_sel        (rom_sel),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  assign rom_data = rom_sel ? rom[rom_addr] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic ready);
    rst_n          = 1'b0;
    inst_ready     = ready;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    hold_reset(1'b1);
    #1;
    checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", inst_valid); else passed++;
    checks++; if (inst_data !== 32'h0) $display("FAIL reset_data: got %h want 0", inst_data); else passed++;
    checks++; if (inst_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", inst_pc); else passed++;
    checks++; if (rom_sel !== 1'b0) $display("FAIL reset_sel: got %0b want 0", rom_sel); else passed++;
    checks++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault: got %0b want 0", fetch_fault); else passed++;
  endtask

  task automatic test_stream();
    tick(); rst_n = 1'b1; #1;
    checks++; if (rom_sel !== 1'b1) $display("FAIL stream_c1_sel: got %0b want 1", rom_sel); else passed++;
    checks++; if (rom_addr !== 10'd0) $display("FAIL stream_c1_addr: got %h want 0", rom_addr); else passed++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL stream_c1_valid: got %0b want 0", inst_valid); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0000 || inst_pc !== 32'h0)
      $display("FAIL stream_A: got v=%0b %h@%h want 1 c0de0000@0", inst_valid, inst_data, inst_pc); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0001 || inst_pc !== 32'h4)
      $display("FAIL stream_B: got v=%0b %h@%h want 1 c0de0001@4", inst_valid, inst_data, inst_pc); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0002 || inst_pc !== 32'h8)
      $display("FAIL stream_C: got v=%0b %h@%h want 1 c0de0002@8", inst_valid, inst_data, inst_pc); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0003 || inst_pc !== 32'hC)
      $display("FAIL stream_D: got v=%0b %h@%h want 1 c0de0003@c", inst_valid, inst_data, inst_pc); else passed++;
  endtask

  task automatic test_backpressure();
    hold_reset(1'b0);
    tick(); rst_n = 1'b1; #1;
    checks++; if (rom_sel !== 1'b1) $display("FAIL bp_c1_sel: got %0b want 1", rom_sel); else passed++;
    tick(); #1;
    checks++; if (rom_sel !== 1'b1 || rom_addr !== 10'd1) $display("FAIL bp_c2_fetch: got sel=%0b addr=%h want 1/1", rom_sel, rom_addr); else passed++;
    tick(); #1;
    checks++; if (rom_sel !== 1'b0) $display("FAIL bp_full_sel: got %0b want 0", rom_sel); else passed++;
    checks++; if (inst_data !== 32'hC0DE_0000 || inst_pc !== 32'h0) $display("FAIL bp_head_c3: got %h@%h want c0de0000@0", inst_data, inst_pc); else passed++;
    tick(); #1;
    checks++; if (rom_addr !== 10'd2 || rom_sel !== 1'b0) $display("FAIL bp_pc_hold: got addr=%h sel=%0b want 2/0", rom_addr, rom_sel); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0000 || inst_pc !== 32'h0)
      $display("FAIL bp_head_c5: got v=%0b %h@%h want 1 c0de0000@0", inst_valid, inst_data, inst_pc); else passed++;
    tick(); inst_ready = 1'b1; #1;
    checks++; if (inst_data !== 32'hC0DE_0000 || rom_sel !== 1'b1 || rom_addr !== 10'd2)
      $display("FAIL bp_release: got %h sel=%0b addr=%h want c0de0000 1 2", inst_data, rom_sel, rom_addr); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0001 || inst_pc !== 32'h4)
      $display("FAIL bp_B: got v=%0b %h@%h want 1 c0de0001@4", inst_valid, inst_data, inst_pc); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0002 || inst_pc !== 32'h8)
      $display("FAIL bp_C: got v=%0b %h@%h want 1 c0de0002@8", inst_valid, inst_data, inst_pc); else passed++;
  endtask

  task automatic test_redirect();
    hold_reset(1'b0);
    tick(); rst_n = 1'b1;
    tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    checks++; if (rom_sel !== 1'b0) $display("FAIL redir_sel_same_cycle: got %0b want 0", rom_sel); else passed++;
    tick(); redirect_valid = 1'b0; inst_ready = 1'b1; #1;
    checks++; if (inst_valid !== 1'b0) $display("FAIL redir_flush_valid: got %0b want 0", inst_valid); else passed++;
    checks++; if (rom_sel !== 1'b1 || rom_addr !== 10'd16) $display("FAIL redir_fetch: got sel=%0b addr=%h want 1/10", rom_sel, rom_addr); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0010 || inst_pc !== 32'h40)
      $display("FAIL redir_target: got v=%0b %h@%h want 1 c0de0010@40", inst_valid, inst_data, inst_pc); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0011 || inst_pc !== 32'h44)
      $display("FAIL redir_next: got v=%0b %h@%h want 1 c0de0011@44", inst_valid, inst_data, inst_pc); else passed++;
  endtask

  task automatic test_wrap();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFF8; #1;
    tick(); redirect_valid = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0 || rom_addr !== 10'h3FE) $display("FAIL wrap_start: got v=%0b addr=%h want 0/3fe", inst_valid, rom_addr); else passed++;
    tick(); #1;
    checks++; if (inst_data !== 32'hC0DE_03FE || inst_pc !== 32'hFF8 || rom_addr !== 10'h3FF)
      $display("FAIL wrap_ff8: got %h@%h addr=%h want c0de03fe@ff8 3ff", inst_data, inst_pc, rom_addr); else passed++;
    tick(); #1;
    checks++; if (inst_data !== 32'hC0DE_03FF || inst_pc !== 32'hFFC || rom_addr !== 10'h000)
      $display("FAIL wrap_ffc: got %h@%h addr=%h want c0de03ff@ffc 0", inst_data, inst_pc, rom_addr); else passed++;
`ifdef INST_FETCH_FAULT_EN
    checks++; if (rom_sel !== 1'b0) $display("FAIL wrap_oob_sel: got %0b want 0", rom_sel); else passed++;
    tick(); #1;
    checks++; if (fetch_fault !== 1'b1 || inst_valid !== 1'b0) $display("FAIL wrap_fault: got fault=%0b v=%0b want 1/0", fetch_fault, inst_valid); else passed++;
`else
    checks++; if (rom_sel !== 1'b1) $display("FAIL wrap_sel: got %0b want 1", rom_sel); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0000 || inst_pc !== 32'h1000 || fetch_fault !== 1'b0)
      $display("FAIL wrap_1000: got v=%0b %h@%h f=%0b want 1 c0de0000@1000 0", inst_valid, inst_data, inst_pc, fetch_fault); else passed++;
`endif
  endtask

  task automatic test_fault();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h42; #1;
    tick(); redirect_valid = 1'b0; #1;
`ifdef INST_FETCH_FAULT_EN
    checks++; if (fetch_fault !== 1'b1 || rom_sel !== 1'b0) $display("FAIL misalign_fault: got fault=%0b sel=%0b want 1/0", fetch_fault, rom_sel); else passed++;
`else
    checks++; if (fetch_fault !== 1'b0 || rom_sel !== 1'b1 || rom_addr !== 10'd16)
      $display("FAIL misalign_forced: got fault=%0b sel=%0b addr=%h want 0/1/10", fetch_fault, rom_sel, rom_addr); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) $display("FAIL misalign_pc: got v=%0b pc=%h want 1/40", inst_valid, inst_pc); else passed++;
`endif
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h80; #1;
    tick(); redirect_valid = 1'b0; #1;
    checks++; if (fetch_fault !== 1'b0 || rom_sel !== 1'b1 || rom_addr !== 10'd32)
      $display("FAIL fault_clear: got fault=%0b sel=%0b addr=%h want 0/1/20", fetch_fault, rom_sel, rom_addr); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0020 || inst_pc !== 32'h80)
      $display("FAIL fault_target: got v=%0b %h@%h want 1 c0de0020@80", inst_valid, inst_data, inst_pc); else passed++;
  endtask

  task automatic test_async_reset();
    tick(); #1;
    checks++; if (inst_valid !== 1'b1) $display("FAIL arst_pre_valid: got %0b want 1", inst_valid); else passed++;
    rst_n = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0)
      $display("FAIL arst_outputs: got v=%0b %h@%h want 0 0@0", inst_valid, inst_data, inst_pc); else passed++;
    checks++; if (rom_sel !== 1'b0 || rom_addr !== 10'd0) $display("FAIL arst_rom: got sel=%0b addr=%h want 0/0", rom_sel, rom_addr); else passed++;
    tick();
    tick(); rst_n = 1'b1; #1;
    checks++; if (rom_sel !== 1'b1 || rom_addr !== 10'd0) $display("FAIL arst_restart_fetch: got sel=%0b addr=%h want 1/0", rom_sel, rom_addr); else passed++;
    tick(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0000 || inst_pc !== 32'h0)
      $display("FAIL arst_restart_A: got v=%0b %h@%h want 1 c0de0000@0", inst_valid, inst_data, inst_pc); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hC0DE_0000 + i;
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_fault();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end: the initiator side of the instruction ROM port. Holds the fetch PC, drives the ROM word address and select, captures returned words into a small instruction queue, and hands instructions with their PCs to decode over a valid/ready handshake. Sits between the 1024-word instruction ROM and the decode stage; branch/jump redirects from execute flush and restart it.

## Interface
- DEPTH, 2: instruction queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000: fetch PC after reset
- ADDR_W, 10: ROM word-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- rom_addr  out  ADDR_W  ROM word address = fetch_pc[ADDR_W+1:2]
- rom_sel  out  1  ROM select; ROM returns 0 when low
- rom_data  in  32  ROM read data, combinational from rom_addr/rom_sel
- redirect_valid  in  1  load new fetch PC, flush queue
- redirect_pc  in  32  redirect target (byte address)
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst_data  out  32  head instruction; 0 when inst_valid=0
- inst_pc  out  32  head PC; 0 when inst_valid=0
- fetch_fault  out  1  sticky fault (see Configuration)

## Operation
- Registers: fetch_pc, queue (data+pc per entry), head/tail pointers, count, fault flag.
- pop = inst_valid & inst_ready. room = (count < DEPTH) | pop.
- fetch = room & ~redirect_valid & ~fault. rom_sel = fetch; rom_addr driven from fetch_pc regardless.
- On fetch: push {rom_data, fetch_pc} at tail; fetch_pc += 4 (32-bit add, carry dropped).
- Push and pop in same cycle when full: both occur, count unchanged.
- redirect_valid: count, head, tail cleared; fetch_pc ← redirect_pc; no push that cycle. Concurrent pop is still a completed handshake from decode's view; queue flushed anyway.
- Address wrap: ROM index uses fetch_pc[ADDR_W+1:2] only.

## Timing
- Reset values: fetch_pc=RESET_PC, count=0, inst_valid=0, inst_data=0, inst_pc=0, rom_sel=0 during reset, fetch_fault=0.
- First cycle after rst_n rises: rom_sel=1, rom_addr=RESET_PC word; inst_valid=1 the following cycle.
- Sustained throughput 1 instruction/cycle with inst_ready held high.
- Redirect in cycle N: inst_valid=0 in N+1 with rom_sel=1 for redirect_pc; target instruction valid in N+2.
- inst_ready low with queue full: rom_sel=0, fetch_pc holds, inst_data/inst_pc stable.
- rst_n assertion mid-operation: all state returns to reset values immediately (async).

## Configuration
- INST_FETCH_FAULT_EN defined: redirect_pc[1:0]≠0, or fetch_pc[31:ADDR_W+2]≠0 at a fetch attempt, sets fetch_fault (sticky). While set, no fetch; queued entries still drain. Cleared by reset or a valid redirect (re-evaluated against the new PC next cycle).
- Undefined: fetch_fault tied 0; redirect_pc[1:0] forced to 0; out-of-range PCs wrap modulo 2^(ADDR_W+2) bytes.

## Structure
- Package mips_fetch_pkg: RESET_PC default, INST_NOP = 32'h0, word_index(pc) helper, fetch entry struct {data, pc}.
- One sub-module: fetch_queue (circular buffer, push/pop/flush, count, head outputs). Top holds PC, select logic, fault logic.

## Test plan
- Reset release, ROM[0..3]=A,B,C,D, inst_ready=1 -> inst_valid from cycle 2, outputs (A,0),(B,4),(C,8),(D,0xC) on consecutive cycles.
- inst_ready=0 for 5 cycles -> queue fills to DEPTH, rom_sel=0 after 2 pushes, head stays (A,0); release -> B, C follow back-to-back with no gaps or duplicates.
- redirect_valid with redirect_pc=0x40 while queue full -> next cycle inst_valid=0, following cycle (ROM[16],0x40); stale entries never appear.
- fetch_pc reaches 0xFFC -> next fetch with macro off: rom_addr=0, inst_pc=0x1000; with macro on: fetch_fault=1, no further pushes.
- Macro on, redirect_pc=0x42 -> fetch_fault=1, rom_sel=0; redirect_pc=0x80 -> fault clears, (ROM[32],0x80) delivered.
- rst_n pulsed low mid-stream -> inst_valid, inst_data, inst_pc, count return to 0 immediately; restart from RESET_PC.
